ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the send side of the keyboard link. It lets the design send command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). It runs the host request-to-send sequence over the shared open-drain PS2_CLOCK/PS2_DATA lines, shifts out data, odd parity and stop, then checks the device acknowledge. It sits beside the existing PS/2 receiver; out_busy lets top level hold that receiver off while a transmit is in progress.

Parameters:
INHIBIT_CYCLES, 5000, in_clock cycles the clock line is held low before RTS (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max in_clock cycles between device clock falling edges, counted from clock release (15 ms at 50 MHz).

Ports:
in_clock  input  1  system clock (50 MHz board clock).
in_reset_n  input  1  asynchronous, active-low reset.
in_start  input  1  one-cycle request to send in_data; ignored while out_busy=1.
in_data  input  8  command byte; captured on the accepted in_start cycle.
ps2_clock_in  input  1  sensed PS/2 clock line (asynchronous).
ps2_data_in  input  1  sensed PS/2 data line (asynchronous).
ps2_clock_oe  output  1  1 = drive clock line low; 0 = release (pull-up).
ps2_data_oe  output  1  1 = drive data line low; 0 = release.
out_busy  output  1  high from the cycle after acceptance until return to IDLE.
out_done  output  1  one-cycle pulse: byte sent and ACK seen.
out_error  output  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset (async, in_reset_n=0): state=IDLE; all outputs 0; both lines released; counters, shift register and synchronizers cleared (synchronizers to 1).
- Both ps2_*_in pass through 2-flop synchronizers. Falling edge = previous synced 1 and current synced 0, so detection lags the pin by 2-3 cycles.
- Byte capture: shift register := {1'b1 stop, ~^in_data odd parity, in_data}, sent LSB first.
- IDLE: in_start=1 moves to INHIBIT next cycle; out_busy=1 from that cycle.
- INHIBIT: ps2_clock_oe=1 for exactly INHIBIT_CYCLES cycles.
- RTS: ps2_data_oe=1 (start bit 0); one cycle later ps2_clock_oe=0. Move to SEND and load the timeout counter.
- SEND: on each device falling edge, drive the next bit (ps2_data_oe = ~bit). Bit count runs 0-7 data, 8 parity, 9 stop (released). After the stop bit go to ACK.
- ACK: on the next falling edge, sample synced data. Data 0 goes to WAIT_IDLE; data 1 goes to ERROR.
- WAIT_IDLE: wait until synced clock=1 and data=1, then pulse out_done, enter IDLE, drop out_busy.
- ERROR: release both lines, pulse out_error, enter IDLE the same cycle.
- Timeout: the counter reloads on every falling edge in SEND/ACK/WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to ERROR.
- out_done and out_error are never high together and each lasts exactly 1 cycle.
- in_start while busy is dropped and does not queue; in_data changes after acceptance have no effect.
- Falling edge and timeout on the same cycle: the edge wins.
- Reset mid-transfer releases both lines immediately and produces no done/error pulse.
- Counter widths are $clog2 of the respective parameter + 1; no wrap is possible because the counters saturate at compare.

Test Plan:
Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. Device model toggles clock with a 40-cycle period, samples data on rising edges, and ACKs by pulling data low on the 11th clock.
1. in_start with in_data=0xED -> clock low exactly 20 cycles; model sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK -> out_done pulses once, out_busy falls.
2. in_data=0xF4 -> parity bit 0; in_data=0xFF -> parity 1; both end with out_done and no out_error.
3. Model never clocks after RTS -> out_error one cycle at 200 cycles after clock release; both oe=0.
4. Model omits the ACK (data stays high on 11th edge) -> out_error, no out_done.
5. Second in_start=0x00 issued mid-transfer -> ignored; the model receives only the first byte.
6. in_reset_n=0 during bit 4 -> both oe=0 asynchronously, out_busy=0, no pulses; a following 0xFF transfer completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shifts out data/parity/stop on
// device clock falling edges, then checks the device acknowledge.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       in_clock,
   input  logic       in_reset_n,
   input  logic       in_start,
   input  logic [7:0] in_data,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   output logic       out_busy,
   output logic       out_done,
   output logic       out_error
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {StIdle, StInhibit, StRts, StSend, StAck, StWaitIdle} state_t;

   state_t        state;
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic [IW-1:0] inhibit_cnt;
   logic [TW-1:0] timeout_cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    shift;

   logic clk_s, data_s, fall, timeout_hit, line_idle, wait_state, to_error;

   // clk_sync[1] is the synchronized level, clk_sync[2] its previous value
   assign clk_s       = clk_sync[1];
   assign data_s      = data_sync[1];
   assign fall        = clk_sync[2] & ~clk_sync[1];
   assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign line_idle   = clk_s & data_s;

   always_comb begin
      wait_state = (state == StSend) || (state == StAck) || (state == StWaitIdle);
      to_error   = 1'b0;
      if (wait_state && !fall && timeout_hit && !(state == StWaitIdle && line_idle)) begin
         to_error = 1'b1;
      end
      if (state == StAck && fall && data_s) begin
         to_error = 1'b1;
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state        <= StIdle;
         clk_sync     <= 3'b111;
         data_sync    <= 2'b11;
         inhibit_cnt  <= '0;
         timeout_cnt  <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         ps2_clock_oe <= 1'b0;
         ps2_data_oe  <= 1'b0;
         out_busy     <= 1'b0;
         out_done     <= 1'b0;
         out_error    <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clock_in};
         data_sync <= {data_sync[0], ps2_data_in};
         out_done  <= 1'b0;
         out_error <= 1'b0;
         if (to_error) begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            out_busy     <= 1'b0;
            out_error    <= 1'b1;
            state        <= StIdle;
         end else begin
            case (state)
               StIdle: begin
                  if (in_start) begin
                     shift        <= {1'b1, ~^in_data, in_data};
                     inhibit_cnt  <= '0;
                     bit_cnt      <= '0;
                     ps2_clock_oe <= 1'b1;
                     out_busy     <= 1'b1;
                     state        <= StInhibit;
                  end
               end
               // Clock stays low through the RTS cycle too, giving INHIBIT_CYCLES in total
               StInhibit: begin
                  if (inhibit_cnt == IW'(INHIBIT_CYCLES - 2)) begin
                     ps2_data_oe <= 1'b1;
                     state       <= StRts;
                  end else begin
                     inhibit_cnt <= inhibit_cnt + IW'(1);
                  end
               end
               StRts: begin
                  ps2_clock_oe <= 1'b0;
                  timeout_cnt  <= '0;
                  state        <= StSend;
               end
               StSend: begin
                  if (fall) begin
                     timeout_cnt <= '0;
                     ps2_data_oe <= ~shift[0];
                     shift       <= {1'b1, shift[9:1]};
                     if (bit_cnt == 4'd9) begin
                        state <= StAck;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end else begin
                     timeout_cnt <= timeout_cnt + TW'(1);
                  end
               end
               StAck: begin
                  if (fall) begin
                     timeout_cnt <= '0;
                     state       <= StWaitIdle;
                  end else begin
                     timeout_cnt <= timeout_cnt + TW'(1);
                  end
               end
               StWaitIdle: begin
                  if (fall) begin
                     timeout_cnt <= '0;
                  end else if (line_idle) begin
                     out_done <= 1'b1;
                     out_busy <= 1'b0;
                     state    <= StIdle;
                  end else begin
                     timeout_cnt <= timeout_cnt + TW'(1);
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks the frame out, and
// independent monitors compare received frames and done/error pulses against a reference.
module tb_ps2_host_tx;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 200;

   logic       in_clock = 1'b0;
   logic       in_reset_n = 1'b1;
   logic       in_start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       clock_oe, data_oe, busy, done, error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   assign clk_line  = ~(clock_oe | dev_clk_low);
   assign data_line = ~(data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .in_clock    (in_clock),
      .in_reset_n  (in_reset_n),
      .in_start    (in_start),
      .in_data     (in_data),
      .ps2_clock_in(clk_line),
      .ps2_data_in (data_line),
      .ps2_clock_oe(clock_oe),
      .ps2_data_oe (data_oe),
      .out_busy    (busy),
      .out_done    (done),
      .out_error   (error)
   );

   always #5 in_clock = ~in_clock;

   int cyc = 0;
   always @(posedge in_clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [9:0] exp_frame_q[$];
   logic [9:0] rx_frame_q[$];
   int         exp_out_q[$];  // 1 = done, 2 = error

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic note_fail(input string name, input string msg);
      tests++;
      fails++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // Reference frame: data LSB first, then odd parity, then stop 1
   function automatic logic [9:0] frame_of(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
   endfunction

   // Frame monitor
   logic [9:0] rx_frame;
   always @(negedge in_clock) begin
      while (rx_frame_q.size() > 0) begin
         rx_frame = rx_frame_q.pop_front();
         if (exp_frame_q.size() == 0) note_fail("frame", $sformatf("unexpected frame 0x%0h", rx_frame));
         else check("frame", int'(rx_frame), int'(exp_frame_q.pop_front()));
      end
   end

   // Outcome monitor
   logic prev_pulse = 1'b0;
   int   err_cyc = 0;
   always @(negedge in_clock) begin
      if (done === 1'b1 || error === 1'b1) begin
         check("pulse_exclusive", int'(done & error), 0);
         check("pulse_width", int'(prev_pulse), 0);
         if (error === 1'b1) err_cyc <= cyc;
         if (exp_out_q.size() == 0)
            note_fail("outcome", $sformatf("unexpected pulse done=%0b error=%0b", done, error));
         else check("outcome", (done === 1'b1) ? 1 : 2, exp_out_q.pop_front());
      end
      prev_pulse <= (done === 1'b1) || (error === 1'b1);
   end

   // Clock-inhibit length and release time
   int low_run = 0;
   int low_len = 0;
   int rel_cyc = 0;
   always @(negedge in_clock) begin
      if (clock_oe === 1'b1) low_run <= low_run + 1;
      else begin
         if (low_run != 0) begin
            low_len <= low_run;
            rel_cyc <= cyc;
         end
         low_run <= 0;
      end
   end

   // mode: 0 normal, 1 device silent, 2 no ACK, 3 aborted by reset during bit 4
   task automatic issue(input logic [7:0] d, input int mode);
      @(negedge in_clock);
      in_start = 1'b1;
      in_data  = d;
      if (mode == 0 || mode == 2) exp_frame_q.push_back(frame_of(d));
      if (mode == 0) exp_out_q.push_back(1);
      if (mode == 1 || mode == 2) exp_out_q.push_back(2);
      @(negedge in_clock);
      in_start = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic device(input int mode);
      int n = 0;
      logic [9:0] bits = '0;
      while (!(clk_line == 1'b1 && data_line == 1'b0) && n < 200) begin
         @(negedge in_clock);
         n++;
      end
      if (n >= 200) begin
         note_fail("rts", "request-to-send not seen within 200 cycles");
         return;
      end
      if (mode == 1) return;
      repeat (8) @(negedge in_clock);
      check("start_bit", int'(data_line), 0);
      for (int i = 0; i < 11; i++) begin
         dev_clk_low = 1'b1;
         if (mode == 3 && i == 4) begin
            repeat (10) @(negedge in_clock);
            return;
         end
         repeat (20) @(negedge in_clock);
         dev_clk_low = 1'b0;
         if (i < 10) bits[i] = data_line;
         if (i == 9 && mode != 2) begin
            repeat (10) @(negedge in_clock);
            dev_data_low = 1'b1;
            repeat (10) @(negedge in_clock);
         end else if (i == 10) begin
            repeat (5) @(negedge in_clock);
            dev_data_low = 1'b0;
         end else begin
            repeat (20) @(negedge in_clock);
         end
      end
      rx_frame_q.push_back(bits);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge in_clock);
         n++;
      end
      if (busy === 1'b1) note_fail("busy_release", "out_busy still high after 3000 cycles");
   endtask

   task automatic post_checks(input string tag);
      repeat (5) @(negedge in_clock);
      check({tag, "_inhibit_len"}, low_len, INH);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_clock_oe"}, int'(clock_oe), 0);
      check({tag, "_data_oe"}, int'(data_oe), 0);
   endtask

   task automatic xfer(input logic [7:0] d, input int mode, input string tag);
      issue(d, mode);
      device(mode);
      wait_idle();
      post_checks(tag);
   endtask

   initial begin
      #1 in_reset_n = 1'b0;
      #20;
      check("reset_clock_oe", int'(clock_oe), 0);
      check("reset_data_oe", int'(data_oe), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_error", int'(error), 0);
      @(negedge in_clock);
      in_reset_n = 1'b1;
      repeat (5) @(negedge in_clock);

      xfer(8'hED, 0, "ed");
      xfer(8'hF4, 0, "f4");
      xfer(8'hFF, 0, "ff");
      for (int k = 0; k < 6; k++) xfer(8'($urandom_range(0, 255)), 0, "rand");

      // Device never clocks: error 200 cycles after clock release
      xfer(8'h3C, 1, "timeout");
      check("timeout_cycles", err_cyc - rel_cyc, TMO);

      // Device withholds ACK
      xfer(8'h5A, 2, "nack");

      // Second request mid-transfer is dropped
      issue(8'h96, 0);
      fork
         device(0);
         begin
            repeat (100) @(negedge in_clock);
            in_start = 1'b1;
            in_data  = 8'h00;
            @(negedge in_clock);
            in_start = 1'b0;
         end
      join
      wait_idle();
      post_checks("busy_start");
      repeat (100) @(negedge in_clock);
      check("no_requeue_busy", int'(busy), 0);

      // Reset while bit 4 (a 0) is on the line
      issue(8'hA5, 3);
      device(3);
      check("abort_data_driven", int'(data_oe), 1);
      @(negedge in_clock);
      #2 in_reset_n = 1'b0;
      #1;
      check("abort_clock_oe", int'(clock_oe), 0);
      check("abort_data_oe", int'(data_oe), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_error", int'(error), 0);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (5) @(negedge in_clock);
      in_reset_n = 1'b1;
      repeat (10) @(negedge in_clock);
      xfer(8'hFF, 0, "after_reset");

      repeat (20) @(negedge in_clock);
      check("frames_left", exp_frame_q.size(), 0);
      check("outcomes_left", exp_out_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
